// File: rtl/vram_console_writer.sv
// vram_console_writer: console byte stream to 64x16 text VRAM writer with cursor, clear and scroll-up
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   char_data/valid/ready   byte stream in (ASCII + CR, LF, BS, FF), valid/ready handshake
//   vram_addr/din/we        VRAM port, address {row, col}, one byte written per cycle
//   vram_dout               VRAM read data, one cycle after vram_addr (sync RAM)
//   cursor_row/col          current cursor position
//   busy                    high whenever a byte cannot be accepted
module vram_console_writer #(
    parameter int         COLS_LOG2 = 6,
    parameter int         ROWS_LOG2 = 4,
    parameter logic [7:0] BLANK     = 8'h20
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [7:0]                     char_data,
    input  logic                           char_valid,
    output logic                           char_ready,
    output logic [ROWS_LOG2+COLS_LOG2-1:0] vram_addr,
    output logic [7:0]                     vram_din,
    output logic                           vram_we,
    input  logic [7:0]                     vram_dout,
    output logic [ROWS_LOG2-1:0]           cursor_row,
    output logic [COLS_LOG2-1:0]           cursor_col,
    output logic                           busy
);
    localparam int AW = ROWS_LOG2 + COLS_LOG2;
    localparam logic [AW-1:0]        ROW_STEP    = AW'(1 << COLS_LOG2);
    localparam logic [AW-1:0]        SCROLL_LAST = AW'(((1 << ROWS_LOG2) - 1) * (1 << COLS_LOG2) - 1);
    localparam logic [AW-1:0]        CNT_MAX     = '1;
    localparam logic [ROWS_LOG2-1:0] ROW_MAX     = '1;
    localparam logic [COLS_LOG2-1:0] COL_MAX     = '1;

    typedef enum logic [2:0] {IDLE, WRITE, CLEAR, SCROLL_RD, SCROLL_WR, CLRLINE} state_t;

    state_t               state, state_n;
    logic [AW-1:0]        cnt, cnt_n, addr_n;
    logic [ROWS_LOG2-1:0] row_n;
    logic [COLS_LOG2-1:0] col_n;
    logic [7:0]           din_q, din_n;
    logic                 adv_q, adv_n, we_n, rdy_n, pass_q, pass_n;

    // Scroll writes forward the read data the RAM returns during the write cycle.
    assign vram_din = pass_q ? vram_dout : din_q;
    assign busy     = ~char_ready;

    // Every output register is loaded with the bus action of the cycle that follows the edge,
    // so an accepted byte is written in the very next cycle. Entering a scroll launches the
    // first read immediately, which is why the scroll begins in SCROLL_WR.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        row_n   = cursor_row;
        col_n   = cursor_col;
        adv_n   = adv_q;
        we_n    = 1'b0;
        addr_n  = vram_addr;
        din_n   = BLANK;
        rdy_n   = 1'b0;
        pass_n  = 1'b0;
        case (state)
            IDLE: begin
                rdy_n = 1'b1;
                if (char_ready && char_valid) begin
                    case (char_data)
                        8'h0D: col_n = '0;
                        8'h0A: begin
                            if (cursor_row != ROW_MAX) row_n = cursor_row + 1'b1;
                            else begin
                                rdy_n   = 1'b0;
                                addr_n  = ROW_STEP;
                                cnt_n   = '0;
                                state_n = SCROLL_WR;
                            end
                        end
                        8'h08: begin
                            if (cursor_col != '0) begin
                                rdy_n   = 1'b0;
                                col_n   = cursor_col - 1'b1;
                                we_n    = 1'b1;
                                addr_n  = {cursor_row, col_n};
                                adv_n   = 1'b0;
                                state_n = WRITE;
                            end
                        end
                        8'h0C: begin
                            rdy_n   = 1'b0;
                            row_n   = '0;
                            col_n   = '0;
                            cnt_n   = '0;
                            state_n = CLEAR;
                        end
                        default: begin
                            rdy_n   = 1'b0;
                            we_n    = 1'b1;
                            addr_n  = {cursor_row, cursor_col};
                            din_n   = char_data;
                            adv_n   = 1'b1;
                            state_n = WRITE;
                        end
                    endcase
                end
            end
            WRITE: begin
                state_n = IDLE;
                rdy_n   = 1'b1;
                if (adv_q) begin
                    col_n = (cursor_col == COL_MAX) ? '0 : cursor_col + 1'b1;
                    if (cursor_col == COL_MAX) begin
                        if (cursor_row != ROW_MAX) row_n = cursor_row + 1'b1;
                        else begin
                            rdy_n   = 1'b0;
                            addr_n  = ROW_STEP;
                            cnt_n   = '0;
                            state_n = SCROLL_WR;
                        end
                    end
                end
            end
            CLEAR: begin
                we_n    = 1'b1;
                addr_n  = cnt;
                cnt_n   = cnt + 1'b1;
                state_n = (cnt == CNT_MAX) ? IDLE : CLEAR;
            end
            SCROLL_RD: begin
                addr_n  = cnt + ROW_STEP;
                state_n = SCROLL_WR;
            end
            SCROLL_WR: begin
                we_n    = 1'b1;
                addr_n  = cnt;
                pass_n  = 1'b1;
                cnt_n   = (cnt == SCROLL_LAST) ? '0 : cnt + 1'b1;
                state_n = (cnt == SCROLL_LAST) ? CLRLINE : SCROLL_RD;
            end
            CLRLINE: begin
                we_n   = 1'b1;
                addr_n = {ROW_MAX, cnt[COLS_LOG2-1:0]};
                cnt_n  = cnt + 1'b1;
                if (cnt[COLS_LOG2-1:0] == COL_MAX) begin
                    cnt_n   = '0;
                    row_n   = ROW_MAX;
                    col_n   = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CLEAR;
            cnt        <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            adv_q      <= 1'b0;
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            din_q      <= BLANK;
            char_ready <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            cursor_row <= row_n;
            cursor_col <= col_n;
            adv_q      <= adv_n;
            vram_we    <= we_n;
            vram_addr  <= addr_n;
            din_q      <= din_n;
            char_ready <= rdy_n;
            pass_q     <= pass_n;
        end
    end
endmodule
